// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes and state encoding for the round-robin arbiter
package arb_pkg;
  localparam int NREQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, GRANT, REVOKE} state_t;
endpackage

// File: rtl/rr_arbiter8_dec.sv
// rr_arbiter8_dec: 3-to-8 one-hot decoder
module rr_arbiter8_dec
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [NREQ-1:0]  onehot
);
  assign onehot = NREQ'(1) << idx;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with level requests and hold timeout
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HMAX = MAX_HOLD == 0 ? '1 : CW'(MAX_HOLD - 1);
  state_t state, state_nx;
  logic [IDX_W-1:0] ptr, pick;
  logic [CW-1:0] hold_cnt;
  logic [NREQ-1:0] dec;
  logic owner_req, expire;
  // downward scan so the lowest offset from ptr wins
  always_comb begin
    pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[ptr + IDX_W'(i)]) pick = ptr + IDX_W'(i);
  end
  assign owner_req = req[grant_idx];
  assign expire = MAX_HOLD != 0 && hold_cnt == HMAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (|req ? GRANT : IDLE) :
               state == GRANT ? (!owner_req ? IDLE : expire ? REVOKE : GRANT) :
               IDLE;
  // release takes priority over expiry because state_nx already encodes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_idx <= '0;
      hold_cnt  <= '0;
      ptr       <= '0;
    end else begin
      if (state == IDLE && |req) begin
        grant_idx <= pick;
        hold_cnt  <= '0;
      end
      if (state == GRANT) begin
        if (state_nx != GRANT) ptr <= grant_idx + 1'b1;
        else if (hold_cnt != HMAX) hold_cnt <= hold_cnt + 1'b1;
      end
    end
  rr_arbiter8_dec u_dec (
    .idx    (grant_idx),
    .onehot (dec)
  );
  always_comb begin
    grant_valid = state == GRANT;
    timeout     = state == REVOKE;
    grant       = grant_valid ? dec : '0;
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench for rr_arbiter8 with MAX_HOLD = 4
module tb_rr_arbiter8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       t;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] stim_q[$];
  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n) begin
    checks += 3;
    if ((grant & (grant - 8'h01)) != 8'h00) begin
      errors++;
      $display("FAIL onehot: grant=%h is not one-hot or zero", grant);
    end
    if (grant_valid !== |grant) begin
      errors++;
      $display("FAIL valid_or: grant_valid=%b required %b", grant_valid, |grant);
    end
    if (grant_valid && grant !== (8'h01 << grant_idx)) begin
      errors++;
      $display("FAIL decode: grant=%h required %h for idx %0d", grant, 8'h01 << grant_idx, grant_idx);
    end
  end
  task automatic push(input logic [7:0] r, input int o, input logic t);
    exp_t e;
    e.g = (o < 0) ? 8'h00 : 8'(8'h01 << o);
    e.i = 3'(o);
    e.t = t;
    stim_q.push_back(r);
    sb.push_back(e);
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    req = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 8'h00 || grant_idx !== 3'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%h idx=%0d valid=%b to=%b required 00/0/0/0", grant, grant_idx, grant_valid, timeout);
    end
    req = 8'h00;
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    exp_t e;
    push(8'h01, 0, 0);
    push(8'h01, 0, 0);
    push(8'h00, -1, 0);
    push(8'h00, -1, 0);
    while (stim_q.size() > 0) begin
      req = stim_q.pop_front();
      @(posedge clk);
      #1 e = sb.pop_front();
      checks++;
      if (grant !== e.g || timeout !== e.t || (e.g != 0 && grant_idx !== e.i)) begin
        errors++;
        $display("FAIL single: grant=%h idx=%0d to=%b required grant=%h idx=%0d to=%b", grant, grant_idx, timeout, e.g, e.i, e.t);
      end
    end
  endtask
  task automatic test_rotation();
    exp_t e;
    logic [7:0] b;
    apply_reset();
    for (int o = 0; o < 9; o++) begin
      b = 8'h01 << (o % 8);
      repeat (3) push(8'hFF, o % 8, 0);
      push(8'hFF & ~b, -1, 0);
    end
    while (stim_q.size() > 0) begin
      req = stim_q.pop_front();
      @(posedge clk);
      #1 e = sb.pop_front();
      checks++;
      if (grant !== e.g || timeout !== e.t || (e.g != 0 && grant_idx !== e.i)) begin
        errors++;
        $display("FAIL rotation: grant=%h idx=%0d to=%b required grant=%h idx=%0d to=%b", grant, grant_idx, timeout, e.g, e.i, e.t);
      end
    end
  endtask
  task automatic test_timeout();
    exp_t e;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      repeat (4) push(8'h24, (r % 2 == 1) ? 5 : 2, 0);
      push(8'h24, -1, 1);
      push(8'h24, -1, 0);
    end
    repeat (4) push(8'h01, 0, 0);
    push(8'h01, -1, 1);
    push(8'h01, -1, 0);
    push(8'h01, 0, 0);
    push(8'h00, -1, 0);
    push(8'h00, -1, 0);
    while (stim_q.size() > 0) begin
      req = stim_q.pop_front();
      @(posedge clk);
      #1 e = sb.pop_front();
      checks++;
      if (grant !== e.g || timeout !== e.t || (e.g != 0 && grant_idx !== e.i)) begin
        errors++;
        $display("FAIL timeout: grant=%h idx=%0d to=%b required grant=%h idx=%0d to=%b", grant, grant_idx, timeout, e.g, e.i, e.t);
      end
    end
  endtask
  task automatic test_wrap();
    exp_t e;
    apply_reset();
    push(8'h40, 6, 0);
    push(8'h00, -1, 0);
    push(8'h41, 0, 0);
    push(8'h43, 0, 0);
    push(8'h81, 0, 0);
    push(8'h00, -1, 0);
    while (stim_q.size() > 0) begin
      req = stim_q.pop_front();
      @(posedge clk);
      #1 e = sb.pop_front();
      checks++;
      if (grant !== e.g || timeout !== e.t || (e.g != 0 && grant_idx !== e.i)) begin
        errors++;
        $display("FAIL wrap: grant=%h idx=%0d to=%b required grant=%h idx=%0d to=%b", grant, grant_idx, timeout, e.g, e.i, e.t);
      end
    end
  endtask
  task automatic test_release_vs_timeout();
    exp_t e;
    apply_reset();
    repeat (4) push(8'h08, 3, 0);
    push(8'h10, -1, 0);
    push(8'h10, 4, 0);
    push(8'h00, -1, 0);
    while (stim_q.size() > 0) begin
      req = stim_q.pop_front();
      @(posedge clk);
      #1 e = sb.pop_front();
      checks++;
      if (grant !== e.g || timeout !== e.t || (e.g != 0 && grant_idx !== e.i)) begin
        errors++;
        $display("FAIL rel_vs_to: grant=%h idx=%0d to=%b required grant=%h idx=%0d to=%b", grant, grant_idx, timeout, e.g, e.i, e.t);
      end
    end
  endtask
  task automatic test_async_reset();
    exp_t e;
    apply_reset();
    push(8'h10, 4, 0);
    push(8'h00, -1, 0);
    push(8'h21, 5, 0);
    while (stim_q.size() > 0) begin
      req = stim_q.pop_front();
      @(posedge clk);
      #1 e = sb.pop_front();
      checks++;
      if (grant !== e.g || timeout !== e.t || (e.g != 0 && grant_idx !== e.i)) begin
        errors++;
        $display("FAIL async_pre: grant=%h idx=%0d to=%b required grant=%h idx=%0d to=%b", grant, grant_idx, timeout, e.g, e.i, e.t);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 8'h00 || grant_idx !== 3'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: grant=%h idx=%0d valid=%b to=%b required 00/0/0/0", grant, grant_idx, grant_valid, timeout);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(8'h21, 0, 0);
    push(8'h00, -1, 0);
    while (stim_q.size() > 0) begin
      req = stim_q.pop_front();
      @(posedge clk);
      #1 e = sb.pop_front();
      checks++;
      if (grant !== e.g || timeout !== e.t || (e.g != 0 && grant_idx !== e.i)) begin
        errors++;
        $display("FAIL async_post: grant=%h idx=%0d to=%b required grant=%h idx=%0d to=%b", grant, grant_idx, timeout, e.g, e.i, e.t);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_wrap();
    test_release_vs_timeout();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
